// File: rtl/rv32i_exec_datapath.sv
// rv32i_exec_datapath: execution datapath leaf for the rv32i multicycle core.
// Contains a combinational RV32I ALU, a 32x32 register file (x0 reads zero,
// two async read ports, one sync write port) and one enabled state register
// (instantiated for PC, PC_old and IR). All control comes from the core FSM.
//
// Optional feature macro: RF_WRITE_BYPASS_EN
//   defined   -> each read port forwards rf_wr_data on a same-cycle write to its address
//   undefined -> same-cycle reads return the stored (old) value
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   reg_ena, reg_d, reg_q    general register enable / next value / current value
//   rf_wr_ena/addr/data      register file write port
//   rf_rd_addr0/1, rf_rd_data0/1  register file read ports
//   alu_a, alu_b, alu_control     ALU operands and operation
//   alu_result, alu_overflow, alu_zero, alu_equal  ALU outputs
module rv32i_exec_datapath #(
    parameter int unsigned      REG_N     = 32,
    parameter logic [REG_N-1:0] REG_RESET = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reg_ena,
    input  logic [REG_N-1:0] reg_d,
    output logic [REG_N-1:0] reg_q,
    input  logic             rf_wr_ena,
    input  logic [4:0]       rf_wr_addr,
    input  logic [31:0]      rf_wr_data,
    input  logic [4:0]       rf_rd_addr0,
    input  logic [4:0]       rf_rd_addr1,
    output logic [31:0]      rf_rd_data0,
    output logic [31:0]      rf_rd_data1,
    input  logic [31:0]      alu_a,
    input  logic [31:0]      alu_b,
    input  logic [3:0]       alu_control,
    output logic [31:0]      alu_result,
    output logic             alu_overflow,
    output logic             alu_zero,
    output logic             alu_equal
);

    localparam int unsigned XLEN = 32;

    localparam logic [3:0] ALU_AND  = 4'b0001;
    localparam logic [3:0] ALU_OR   = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_ADD  = 4'b1000;
    localparam logic [3:0] ALU_SUB  = 4'b1100;
    localparam logic [3:0] ALU_SLT  = 4'b1101;
    localparam logic [3:0] ALU_SLTU = 4'b1111;

    // General enabled state register
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_q <= REG_RESET;
        end else if (reg_ena) begin
            reg_q <= reg_d;
        end
    end

    // Register file storage; x0 has no storage and always reads zero
    logic [XLEN-1:0] rf_mem [1:31];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                rf_mem[i] <= '0;
            end
        end else if (rf_wr_ena && (rf_wr_addr != 5'd0)) begin
            rf_mem[rf_wr_addr] <= rf_wr_data;
        end
    end

    // Asynchronous read ports
    always_comb begin
        rf_rd_data0 = '0;
        rf_rd_data1 = '0;
        if (rf_rd_addr0 != 5'd0) begin
            rf_rd_data0 = rf_mem[rf_rd_addr0];
        end
        if (rf_rd_addr1 != 5'd0) begin
            rf_rd_data1 = rf_mem[rf_rd_addr1];
        end
`ifdef RF_WRITE_BYPASS_EN
        // Forward the in-flight write so the reader sees the new value this cycle
        if (rf_wr_ena && !rst && (rf_wr_addr != 5'd0) && (rf_wr_addr == rf_rd_addr0)) begin
            rf_rd_data0 = rf_wr_data;
        end
        if (rf_wr_ena && !rst && (rf_wr_addr != 5'd0) && (rf_wr_addr == rf_rd_addr1)) begin
            rf_rd_data1 = rf_wr_data;
        end
`endif
    end

    // ALU
    logic [XLEN-1:0] alu_sum;
    logic [XLEN-1:0] alu_diff;
    logic [4:0]      alu_shamt;

    assign alu_sum   = alu_a + alu_b;
    assign alu_diff  = alu_a - alu_b;
    assign alu_shamt = alu_b[4:0];

    always_comb begin
        alu_result   = '0;
        alu_overflow = 1'b0;
        case (alu_control)
            ALU_AND:  alu_result = alu_a & alu_b;
            ALU_OR:   alu_result = alu_a | alu_b;
            ALU_XOR:  alu_result = alu_a ^ alu_b;
            ALU_SLL:  alu_result = alu_a << alu_shamt;
            ALU_SRL:  alu_result = alu_a >> alu_shamt;
            ALU_SRA:  alu_result = XLEN'($signed(alu_a) >>> alu_shamt);
            ALU_ADD: begin
                alu_result   = alu_sum;
                // Same-sign operands producing an opposite-sign sum
                alu_overflow = (alu_a[31] == alu_b[31]) && (alu_sum[31] != alu_a[31]);
            end
            ALU_SUB: begin
                alu_result   = alu_diff;
                // Opposite-sign operands with the result sign flipped from a
                alu_overflow = (alu_a[31] != alu_b[31]) && (alu_diff[31] != alu_a[31]);
            end
            ALU_SLT:  alu_result = {31'd0, ($signed(alu_a) < $signed(alu_b))};
            ALU_SLTU: alu_result = {31'd0, (alu_a < alu_b)};
            default:  alu_result = '0;
        endcase
    end

    assign alu_zero  = (alu_result == '0);
    assign alu_equal = (alu_a == alu_b);

endmodule

// File: tb/tb_rv32i_exec_datapath.sv
// Self-checking bench for rv32i_exec_datapath: directed ALU vector table,
// hand-written register/RF sequences, and randomized ALU and register file
// traffic compared against an arithmetic reference model.
module tb_rv32i_exec_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_ena;
    logic [31:0] reg_d;
    logic [31:0] reg_q;
    logic        rf_wr_ena;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic [4:0]  rf_rd_addr0;
    logic [4:0]  rf_rd_addr1;
    logic [31:0] rf_rd_data0;
    logic [31:0] rf_rd_data1;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_control;
    logic [31:0] alu_result;
    logic        alu_overflow;
    logic        alu_zero;
    logic        alu_equal;

    rv32i_exec_datapath #(.REG_N(32), .REG_RESET(32'h100)) dut (
        .clk(clk), .rst(rst),
        .reg_ena(reg_ena), .reg_d(reg_d), .reg_q(reg_q),
        .rf_wr_ena(rf_wr_ena), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .rf_rd_addr0(rf_rd_addr0), .rf_rd_addr1(rf_rd_addr1),
        .rf_rd_data0(rf_rd_data0), .rf_rd_data1(rf_rd_data1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_overflow(alu_overflow),
        .alu_zero(alu_zero), .alu_equal(alu_equal)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    // Move past the next rising edge and settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
        logic        zero;
        logic        eq;
    } alu_vec_t;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
    } alu_ref_t;

    // Reference ALU from the arithmetic definition of each operation
    function automatic alu_ref_t alu_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        alu_ref_t r;
        longint sa, sb, wide;
        int unsigned sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b) & 31;
        r.res = 32'd0;
        r.ovf = 1'b0;
        case (c)
            4'd1:  r.res = a & b;
            4'd2:  r.res = a | b;
            4'd3:  r.res = a ^ b;
            4'd5:  r.res = a << sh;
            4'd6:  r.res = a >> sh;
            4'd7:  r.res = 32'(sa >>> sh);
            4'd8: begin
                wide  = sa + sb;
                r.res = 32'(wide);
                r.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            4'd12: begin
                wide  = sa - sb;
                r.res = 32'(wide);
                r.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            4'd13: r.res = (sa < sb) ? 32'd1 : 32'd0;
            4'd15: r.res = (a < b) ? 32'd1 : 32'd0;
            default: r.res = 32'd0;
        endcase
        return r;
    endfunction

    logic [31:0] rf_model [32];

    function automatic logic [31:0] rf_expect(input logic [4:0] ra);
        logic [31:0] v;
        v = (ra == 5'd0) ? 32'd0 : rf_model[ra];
`ifdef RF_WRITE_BYPASS_EN
        if (rf_wr_ena && !rst && rf_wr_addr != 5'd0 && rf_wr_addr == ra) v = rf_wr_data;
`endif
        return v;
    endfunction

    alu_vec_t vecs[15];

    initial begin
        alu_ref_t r;
        logic [31:0] exp_same;

        vecs[0]  = '{4'b1000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{4'b1000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{4'b1100, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{4'b1100, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{4'b1101, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{4'b1111, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{4'b0111, 32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{4'b0110, 32'h80000000, 32'h00000024, 32'h08000000, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{4'b0101, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{4'b0011, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{4'b1001, 32'h12345678, 32'h12345678, 32'h00000000, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{4'b1100, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; reg_ena = 1'b0; reg_d = 32'd0;
        rf_wr_ena = 1'b0; rf_wr_addr = 5'd0; rf_wr_data = 32'd0;
        rf_rd_addr0 = 5'd0; rf_rd_addr1 = 5'd0;
        alu_a = 32'd0; alu_b = 32'd0; alu_control = 4'd0;

        // General register reset and enable behaviour
        step();
        rst = 1'b0;
        chk("reg_reset", reg_q, 32'h100);
        reg_d = 32'd5;
        step();
        chk("reg_hold", reg_q, 32'h100);
        reg_ena = 1'b1;
        step();
        chk("reg_load", reg_q, 32'd5);
        rst = 1'b1; reg_d = 32'd9;
        step();
        chk("reg_rst_prio", reg_q, 32'h100);
        rst = 1'b0; reg_ena = 1'b0;

        // x0 writes dropped, normal write/read on both ports
        rf_wr_ena = 1'b1; rf_wr_addr = 5'd0; rf_wr_data = 32'hDEADBEEF;
        step();
        rf_wr_addr = 5'd5; rf_wr_data = 32'd7;
        rf_rd_addr0 = 5'd0;
        #1 chk("rf_x0_read", rf_rd_data0, 32'd0);
        step();
        rf_wr_addr = 5'd31; rf_wr_data = 32'hFFFFFFFF;
        step();
        rf_wr_ena = 1'b0;
        rf_rd_addr0 = 5'd5; rf_rd_addr1 = 5'd31;
        #1;
        chk("rf_rd0_x5", rf_rd_data0, 32'd7);
        chk("rf_rd1_x31", rf_rd_data1, 32'hFFFFFFFF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rf_rst_rd0", rf_rd_data0, 32'd0);
        chk("rf_rst_rd1", rf_rd_data1, 32'd0);

        // Same-cycle read of a register being written
        rf_wr_ena = 1'b1; rf_wr_addr = 5'd3; rf_wr_data = 32'd1;
        step();
        rf_wr_data = 32'd2; rf_rd_addr0 = 5'd3; rf_rd_addr1 = 5'd3;
`ifdef RF_WRITE_BYPASS_EN
        exp_same = 32'd2;
`else
        exp_same = 32'd1;
`endif
        #1;
        chk("rf_same_cycle_rd0", rf_rd_data0, exp_same);
        chk("rf_same_cycle_rd1", rf_rd_data1, exp_same);
        step();
        rf_wr_ena = 1'b0;
        #1 chk("rf_after_edge", rf_rd_data0, 32'd2);

        // Directed ALU vectors
        foreach (vecs[i]) begin
            alu_control = vecs[i].ctrl; alu_a = vecs[i].a; alu_b = vecs[i].b;
            #1;
            chk($sformatf("alu_res[%0d]", i), alu_result, vecs[i].res);
            chk($sformatf("alu_ovf[%0d]", i), 32'(alu_overflow), 32'(vecs[i].ovf));
            chk($sformatf("alu_zero[%0d]", i), 32'(alu_zero), 32'(vecs[i].zero));
            chk($sformatf("alu_eq[%0d]", i), 32'(alu_equal), 32'(vecs[i].eq));
        end

        // Randomized ALU against the reference model
        for (int i = 0; i < 400; i++) begin
            alu_control = 4'($urandom_range(0, 15));
            alu_a = $urandom;
            alu_b = ($urandom_range(0, 7) == 0) ? alu_a : $urandom;
            if ($urandom_range(0, 5) == 0) alu_a = 32'h80000000 ^ 32'($urandom_range(0, 3));
            #1;
            r = alu_model(alu_control, alu_a, alu_b);
            chk("alu_rand_res", alu_result, r.res);
            chk("alu_rand_ovf", 32'(alu_overflow), 32'(r.ovf));
            chk("alu_rand_zero", 32'(alu_zero), 32'(r.res == 32'd0));
            chk("alu_rand_eq", 32'(alu_equal), 32'(alu_a == alu_b));
        end

        // Randomized register file traffic against an array model
        rst = 1'b1;
        step();
        foreach (rf_model[i]) rf_model[i] = 32'd0;
        for (int i = 0; i < 300; i++) begin
            rst         = ($urandom_range(0, 40) == 0);
            rf_wr_ena   = ($urandom_range(0, 2) != 0);
            rf_wr_addr  = 5'($urandom_range(0, 31));
            rf_wr_data  = $urandom;
            rf_rd_addr0 = ($urandom_range(0, 3) == 0) ? rf_wr_addr : 5'($urandom_range(0, 31));
            rf_rd_addr1 = ($urandom_range(0, 3) == 0) ? rf_wr_addr : 5'($urandom_range(0, 31));
            #1;
            chk("rf_rand_rd0", rf_rd_data0, rf_expect(rf_rd_addr0));
            chk("rf_rand_rd1", rf_rd_data1, rf_expect(rf_rd_addr1));
            step();
            if (rst) begin
                foreach (rf_model[j]) rf_model[j] = 32'd0;
            end else if (rf_wr_ena && rf_wr_addr != 5'd0) begin
                rf_model[rf_wr_addr] = rf_wr_data;
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/rv32i_exec_datapath.md
Name: rv32i_exec_datapath

Overview:
Execution datapath leaf for the rv32i multicycle core. Bundles three parts:
- a combinational 32-bit RV32I ALU;
- a 32x32 register file with two read ports and one write port (x0 hardwired to zero);
- one general-purpose enabled state register, used for PC, PC_old and IR instances.

The core FSM drives all control inputs directly. This block holds no control state of its own.

Parameters:
- REG_N, 32: width of the general-purpose register (reg_d/reg_q).
- REG_RESET, 0: value loaded into reg_q on reset (e.g. PC_START_ADDRESS).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- reg_ena  in  1  load enable for the general register.
- reg_d  in  REG_N  general register next value.
- reg_q  out  REG_N  general register current value.
- rf_wr_ena  in  1  register file write enable.
- rf_wr_addr  in  5  write register index.
- rf_wr_data  in  32  write data.
- rf_rd_addr0  in  5  read port 0 index (rs1).
- rf_rd_addr1  in  5  read port 1 index (rs2).
- rf_rd_data0  out  32  read port 0 data.
- rf_rd_data1  out  32  read port 1 data.
- alu_a  in  32  ALU operand A.
- alu_b  in  32  ALU operand B.
- alu_control  in  4  ALU operation (alu_control_t encoding).
- alu_result  out  32  ALU result.
- alu_overflow  out  1  signed overflow flag.
- alu_zero  out  1  result == 0.
- alu_equal  out  1  alu_a == alu_b.

Behaviour:
Clock and reset:
- One clock (clk). Reset rst is synchronous and active-high.
- rst has priority over every enable.

General register:
- On a clk edge with rst=1: reg_q <= REG_RESET.
- Else, if reg_ena=1: reg_q <= reg_d.
- Otherwise reg_q holds its value.

Register file:
- 31 storage words x1..x31.
- On a rst edge, all words clear to 0.
- Write: on a clk edge with rf_wr_ena=1, rf_wr_addr!=0 and rst=0, word[rf_wr_addr] <= rf_wr_data.
- Writes to x0 are silently dropped.
- Reads are combinational (asynchronous). Address 0 always reads 0.
- Both read ports are independent. Both may address the same register.
- Read during a same-cycle write to the same address returns the OLD value. The new value is visible after the edge (the bypass macro below changes this).

ALU:
- Purely combinational, zero latency.
- alu_control encoding (4 bits):
  - INVALID 0000
  - AND 0001
  - OR 0010
  - XOR 0011
  - SLL 0101
  - SRL 0110
  - SRA 0111
  - ADD 1000
  - SUB 1100
  - SLT 1101
  - SLTU 1111
- ADD/SUB are 32-bit modular (wrap-around); the carry-out is discarded.
- Shifts use alu_b[4:0] only; alu_b[31:5] are ignored. SRA sign-extends from alu_a[31].
- SLT is a signed compare, SLTU an unsigned compare. Result is 32'd1 if a<b, else 32'd0.
- Any undefined or INVALID code gives result 0.
- alu_overflow: ADD sets it when both operands share a sign and the result's sign differs. SUB sets it when the operands differ in sign and the result's sign differs from alu_a. It is 0 for all other operations.
- alu_zero = (alu_result == 0), for every operation, including INVALID (so INVALID gives zero=1).
- alu_equal = (alu_a == alu_b), regardless of alu_control.

Outputs at reset:
- reg_q = REG_RESET.
- rf_rd_data0/1 = 0 for every address.
- ALU outputs follow their inputs at all times; they are not affected by rst.

Optional Feature:
Macro: RF_WRITE_BYPASS_EN.
- Defined: each read port forwards rf_wr_data combinationally when rf_wr_ena=1, rst=0, rf_wr_addr == the port's read address, and that address is not 0.
- Not defined: a same-cycle read returns the stored (old) value. No forwarding logic is synthesized.

Test Plan:
- Reset/general register: REG_RESET=32'h100, assert rst one edge -> reg_q=0x100. reg_ena=0, reg_d=5, edge -> reg_q=0x100. reg_ena=1, edge -> reg_q=5. rst=1 together with reg_ena=1, reg_d=9 -> reg_q=0x100.
- Register file x0 and write/read: write x0<=0xDEADBEEF, then read addr0=0 -> 0. Write x5<=7 and x31<=0xFFFFFFFF, read both ports (5,31) -> 7 and 0xFFFFFFFF. rst edge -> all reads return 0.
- Same-cycle read/write: x3=1, then write x3<=2 with rd_addr0=3 before the edge -> rd_data0=1 (without bypass) or 2 (with RF_WRITE_BYPASS_EN). After the edge -> 2.
- ALU arithmetic and overflow:
  - ADD 0x7FFFFFFF+1 -> 0x80000000, overflow=1.
  - ADD 0xFFFFFFFF+1 -> 0, zero=1, overflow=0.
  - SUB 0x80000000-1 -> 0x7FFFFFFF, overflow=1.
  - SUB 5-5 -> 0, zero=1, equal=1.
- ALU compare and shift:
  - SLT 0xFFFFFFFF,1 -> 1. SLTU 0xFFFFFFFF,1 -> 0.
  - SRA 0x80000000 by b=0x24 (shamt 4) -> 0xF8000000. SRL same -> 0x08000000.
  - SLL 1 by 31 -> 0x80000000.
- ALU logic and invalid:
  - AND/OR/XOR on 0xF0F0F0F0, 0xFF00FF00 -> 0xF000F000 / 0xFFF0FFF0 / 0x0FF00FF0.
  - INVALID code -> result 0, zero=1, overflow=0.
